// File: rtl/serdes_pkg.sv
// Shared types and helpers for the serial link receive path.
// Optional SERDES_RX_PARITY_EN adds one even-parity bit to every frame.
package serdes_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_SHIFT,
        RX_PARITY
    } rx_state_e;

    function automatic int rx_frame_len(input int data_width);
`ifdef SERDES_RX_PARITY_EN
        return data_width + 1;
`else
        return data_width;
`endif
    endfunction

endpackage

// File: rtl/serdes_rx_shifter.sv
// Frame FSM and LSB-first shift register; flags a completed word combinationally on its final bit.
// SERDES_RX_PARITY_EN adds the PARITY state and the parity_err pulse.
module serdes_rx_shifter
    import serdes_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  serial_in,
    input  logic                  enable,
    input  logic                  start,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  word_valid,
`ifdef SERDES_RX_PARITY_EN
    output logic                  parity_err,
`endif
    output logic                  abort
);

    localparam int CW = $clog2(rx_frame_len(DATA_WIDTH));

    rx_state_e             state_reg, state_next;
    logic [CW-1:0]         cnt_reg, cnt_next;
    logic [DATA_WIDTH-1:0] shreg_reg, shreg_next;
    logic                  abort_reg, abort_next;
    logic                  perr_reg, perr_next;
    logic [DATA_WIDTH-1:0] shifted;

    // Bits enter at the MSB so that after DATA_WIDTH shifts bit 0 sits at the LSB.
    assign shifted = {serial_in, shreg_reg[DATA_WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RX_IDLE;
            cnt_reg   <= '0;
            shreg_reg <= '0;
            abort_reg <= 1'b0;
            perr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            shreg_reg <= shreg_next;
            abort_reg <= abort_next;
            perr_reg  <= perr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        shreg_next = shreg_reg;
        abort_next = 1'b0;
        perr_next  = 1'b0;
        word       = shreg_reg;
        word_valid = 1'b0;
        case (state_reg)
            RX_IDLE: begin
                if (enable && start) begin
                    shreg_next = shifted;
                    cnt_next   = CW'(1);
                    state_next = RX_SHIFT;
                end
            end
            RX_SHIFT: begin
                if (enable && start) begin
                    abort_next = 1'b1;
                    shreg_next = shifted;
                    cnt_next   = CW'(1);
                end else if (enable) begin
                    shreg_next = shifted;
                    cnt_next   = cnt_reg + CW'(1);
                    if (cnt_reg == CW'(DATA_WIDTH - 1)) begin
                        cnt_next = '0;
`ifdef SERDES_RX_PARITY_EN
                        state_next = RX_PARITY;
`else
                        word       = shifted;
                        word_valid = 1'b1;
                        state_next = RX_IDLE;
`endif
                    end
                end
            end
`ifdef SERDES_RX_PARITY_EN
            RX_PARITY: begin
                if (enable && start) begin
                    abort_next = 1'b1;
                    shreg_next = shifted;
                    cnt_next   = CW'(1);
                    state_next = RX_SHIFT;
                end else if (enable) begin
                    // Even parity: the parity bit equals the XOR of the data bits.
                    if (serial_in == ^shreg_reg) begin
                        word_valid = 1'b1;
                    end else begin
                        perr_next = 1'b1;
                    end
                    state_next = RX_IDLE;
                end
            end
`endif
            default: state_next = RX_IDLE;
        endcase
    end

    assign abort = abort_reg;
`ifdef SERDES_RX_PARITY_EN
    assign parity_err = perr_reg;
`else
    logic unused_perr;
    assign unused_perr = perr_reg;
`endif

endmodule

// File: rtl/serdes_rx_link.sv
// Serial link receiver: shifter front end plus ring buffer with valid/ready output and drop accounting.
// SERDES_RX_PARITY_EN adds the parity_err_o port and parity-checked frames.
module serdes_rx_link
    import serdes_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int RX_FIFO_DEPTH = 4,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  serial_in_i,
    input  logic                  enable_i,
    input  logic                  start_i,
    output logic [DATA_WIDTH-1:0] parallel_out_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  overflow_o,
    output logic                  abort_o,
    output logic [CNT_WIDTH-1:0]  drop_count_o,
    output logic                  fifo_full_o,
`ifdef SERDES_RX_PARITY_EN
    output logic                  parity_err_o,
`endif
    output logic                  fifo_empty_o
);

    localparam int AW = $clog2(RX_FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] word;
    logic                  word_valid;
    logic [DATA_WIDTH-1:0] mem [RX_FIFO_DEPTH];
    logic [AW:0]           wr_ptr_reg, rd_ptr_reg;
    logic [CNT_WIDTH-1:0]  drop_cnt_reg;
    logic                  overflow_reg;
    logic                  full, empty, pop, wr_en, drop;

    serdes_rx_shifter #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_shifter (
        .clk        (clk_i),
        .rst_n      (rst_n_i),
        .serial_in  (serial_in_i),
        .enable     (enable_i),
        .start      (start_i),
        .word       (word),
        .word_valid (word_valid),
`ifdef SERDES_RX_PARITY_EN
        .parity_err (parity_err_o),
`endif
        .abort      (abort_o)
    );

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop   = !empty && ready_i;
    // A same-cycle pop frees the slot the incoming word needs.
    assign wr_en = word_valid && (!full || pop);
    assign drop  = word_valid && full && !pop;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < RX_FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= word;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            drop_cnt_reg <= '0;
            overflow_reg <= 1'b0;
        end else begin
            overflow_reg <= drop;
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            if (drop && (drop_cnt_reg != '1)) begin
                drop_cnt_reg <= drop_cnt_reg + CNT_WIDTH'(1);
            end
        end
    end

    assign parallel_out_o = mem[rd_ptr_reg[AW-1:0]];
    assign valid_o        = !empty;
    assign overflow_o     = overflow_reg;
    assign drop_count_o   = drop_cnt_reg;
    assign fifo_full_o    = full;
    assign fifo_empty_o   = empty;

endmodule

// File: tb/tb_serdes_rx_link.sv
// Scoreboard bench for serdes_rx_link: frame-level reference model feeds an expected-word queue.
// Build with SERDES_RX_PARITY_EN defined to exercise the parity frame format.
module tb_serdes_rx_link;

    localparam int DW      = 8;
    localparam int DEPTH   = 4;
    localparam int CW      = 8;
    localparam int CNT_MAX = (1 << CW) - 1;
`ifdef SERDES_RX_PARITY_EN
    localparam int FLEN = DW + 1;
`else
    localparam int FLEN = DW;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sin = 1'b0, en = 1'b0, st = 1'b0, rdy = 1'b0;
    logic [DW-1:0] pout;
    logic          valid, ovf, abrt, full, empty;
    logic [CW-1:0] dcnt;
`ifdef SERDES_RX_PARITY_EN
    logic          perr;
`endif

    always #5 clk = ~clk;

    serdes_rx_link #(
        .DATA_WIDTH(DW), .RX_FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .serial_in_i    (sin),
        .enable_i       (en),
        .start_i        (st),
        .parallel_out_o (pout),
        .valid_o        (valid),
        .ready_i        (rdy),
        .overflow_o     (ovf),
        .abort_o        (abrt),
        .drop_count_o   (dcnt),
        .fifo_full_o    (full),
`ifdef SERDES_RX_PARITY_EN
        .parity_err_o   (perr),
`endif
        .fifo_empty_o   (empty)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state (frame level) and scoreboard.
    bit            bits[$];
    bit            in_frame = 0;
    int            exp_occ = 0;
    int            drops = 0, exp_drops = 0;
    bit            exp_ovf = 0, exp_abort = 0, exp_perr = 0;
    logic [DW-1:0] sb[$];
    int            rdy_mode = 1;
    logic [DW-1:0] last_rx = '0;
    int            n_abort = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit pick_rdy();
        if (rdy_mode == 0) return 1'b0;
        if (rdy_mode == 1) return 1'b1;
        return 1'($urandom_range(1, 0));
    endfunction

    // Drive one cycle of inputs and predict what the DUT shows after the coming edge.
    task automatic step(input bit e, input bit s, input bit d, input bit r);
        bit ab, ov, pe;
        int nocc, ones;
        logic [DW-1:0] w;
        ab = 0; ov = 0; pe = 0;
        en = e; st = s; sin = d; rdy = r;
        nocc = exp_occ - ((exp_occ > 0 && r) ? 1 : 0);
        if (e && s) begin
            ab = in_frame;
            bits.delete();
            bits.push_back(d);
            in_frame = 1;
        end else if (e && in_frame) begin
            bits.push_back(d);
            if (bits.size() == FLEN) begin
                in_frame = 0;
                w = '0;
                ones = 0;
                for (int i = 0; i < FLEN; i++) begin
                    if (i < DW) w[i] = bits[i];
                    ones += int'(bits[i]);
                end
                bits.delete();
                if (ones % 2 != 0 && FLEN > DW) begin
                    pe = 1;
                end else if (nocc < DEPTH) begin
                    sb.push_back(w);
                    nocc++;
                end else begin
                    ov = 1;
                    if (drops < CNT_MAX) drops++;
                end
            end
        end
        @(posedge clk);
        exp_occ = nocc; exp_ovf = ov; exp_abort = ab; exp_perr = pe; exp_drops = drops;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, pick_rdy());
    endtask

    task automatic send_frame(input logic [DW-1:0] w, input bit pflip,
                              input int gmin, input int gmax, input int nbits);
        bit b;
        int g;
        for (int i = 0; i < nbits; i++) begin
            g = (i == 0) ? 0 : int'($urandom_range(gmax, gmin));
            for (int k = 0; k < g; k++) step(0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), pick_rdy());
            b = (i < DW) ? w[i] : ((^w) ^ pflip);
            step(1, i == 0, b, pick_rdy());
        end
    endtask

    task automatic reset_checks();
        chk("rst_data", pout, 0);
        chk("rst_valid", valid, 0);
        chk("rst_overflow", ovf, 0);
        chk("rst_abort", abrt, 0);
        chk("rst_drop_count", dcnt, 0);
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 1);
`ifdef SERDES_RX_PARITY_EN
        chk("rst_parity_err", perr, 0);
`endif
    endtask

    // Monitor: mid-cycle sampling of flags; pops the scoreboard on each valid&ready transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid", valid, exp_occ > 0);
            chk("full", full, exp_occ == DEPTH);
            chk("empty", empty, exp_occ == 0);
            chk("overflow", ovf, exp_ovf);
            chk("abort", abrt, exp_abort);
            chk("drop_count", dcnt, exp_drops);
`ifdef SERDES_RX_PARITY_EN
            chk("parity_err", perr, exp_perr);
`endif
            if (abrt === 1'b1) n_abort++;
            if (valid === 1'b1 && rdy) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL data: got %02h want none (unexpected word) at %0t", pout, $time);
                end else begin
                    logic [DW-1:0] w;
                    w = sb.pop_front();
                    $display("rx word %02h expected %02h at %0t", pout, w, $time);
                    chk("data", pout, w);
                    last_rx = pout;
                end
            end
        end
    end

    initial begin
        #2;
        reset_checks();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single frame, enable every cycle.
        rdy_mode = 1;
        send_frame(8'hA5, 0, 0, 0, FLEN);
        idle(3);
        chk("a5_received", last_rx, 8'hA5);

        // Two-cycle gaps between bits.
        send_frame(8'h3C, 0, 2, 2, FLEN);
        idle(3);
        chk("3c_received", last_rx, 8'h3C);
        chk("3c_no_abort", n_abort, 0);

        // Backpressure: five back-to-back frames into a four-entry buffer.
        rdy_mode = 0;
        for (int i = 1; i <= 5; i++) send_frame(DW'(i), 0, 0, 0, FLEN);
        idle(1);
        chk("bp_full", full, 1);
        chk("bp_drop_count", dcnt, 1);
        rdy_mode = 1;
        idle(6);
        chk("bp_last_drained", last_rx, 8'h04);

        // Restart after three bits of 0xFF.
        send_frame(8'hFF, 0, 0, 0, 3);
        send_frame(8'h12, 0, 0, 0, FLEN);
        idle(3);
        chk("abort_seen", n_abort, 1);
        chk("abort_then_12", last_rx, 8'h12);

`ifdef SERDES_RX_PARITY_EN
        send_frame(8'h03, 1, 0, 0, FLEN);
        idle(3);
        chk("parity_bad_dropped", last_rx, 8'h12);
        send_frame(8'h03, 0, 0, 0, FLEN);
        idle(3);
        chk("parity_good_03", last_rx, 8'h03);
`endif

        // Asynchronous reset mid-frame with two buffered words.
        rdy_mode = 0;
        send_frame(8'h55, 0, 0, 0, FLEN);
        send_frame(8'h66, 0, 0, 0, FLEN);
        send_frame(8'h99, 0, 0, 0, 3);
        rst_n = 1'b0;
        sb.delete(); bits.delete(); in_frame = 0;
        exp_occ = 0; drops = 0; exp_drops = 0; exp_ovf = 0; exp_abort = 0; exp_perr = 0;
        #1;
        reset_checks();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        rdy_mode = 1;
        send_frame(8'h77, 0, 0, 0, FLEN);
        idle(3);
        chk("post_reset_77", last_rx, 8'h77);

        // Randomised traffic: gaps, random ready, stray enables, occasional restarts.
        rdy_mode = 2;
        for (int f = 0; f < 80; f++) begin
            if ($urandom_range(9, 0) == 0) step(1, 0, 1'($urandom_range(1, 0)), pick_rdy());
            if ($urandom_range(9, 0) == 0)
                send_frame(DW'($urandom), 0, 0, 2, int'($urandom_range(FLEN - 1, 1)));
            send_frame(DW'($urandom), 1'($urandom_range(7, 0) == 0), 0, 2, FLEN);
            idle(int'($urandom_range(3, 0)));
        end
        rdy_mode = 1;
        idle(8);

        // Drop counter saturation with the consumer stalled.
        rdy_mode = 0;
        for (int f = 0; f < DEPTH + CNT_MAX + 3; f++) send_frame(DW'($urandom), 0, 0, 0, FLEN);
        idle(1);
        chk("drop_saturated", dcnt, CNT_MAX);
        rdy_mode = 1;
        idle(8);
        chk("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
